pixel_frame_sequencer: RTL

//  Frame-level controller for the 2x2 pixelArray. Runs the erase/expose/convert/read

---
 rtl/pixel_frame_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_frame_sequencer.sv
// Frame controller for the 2x2 pixel array: erase/expose/convert/read sequencing,
// ADC ramp count generation and frame handoff over a valid/ready handshake.
module pixel_frame_sequencer #(
    parameter int unsigned ERASE_CYCLES   = 5,
    parameter int unsigned CONVERT_CYCLES = 256,
    parameter int unsigned READ_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        cont_mode,
    input  logic [15:0] exp_cycles,
    input  logic [7:0]  pix_data1,
    input  logic [7:0]  pix_data2,
    input  logic [7:0]  pix_data3,
    input  logic [7:0]  pix_data4,
    output logic        erase,
    output logic        expose,
    output logic        convert,
    output logic        read12,
    output logic        read34,
    output logic [7:0]  adc_count,
    output logic        busy,
    output logic [31:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready
);

    localparam logic [15:0] ERASE_LEN = 16'(ERASE_CYCLES);
    localparam logic [15:0] CONV_LEN  = 16'(CONVERT_CYCLES);
    localparam logic [15:0] READ_LEN  = 16'(READ_CYCLES);
    localparam logic [15:0] READ_LAST = READ_LEN - 16'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ12,
        S_READ34,
        S_OUT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] pix12_q, pix34_q;

    logic        erase_q, erase_d;
    logic        expose_q, expose_d;
    logic        convert_q, convert_d;
    logic        read12_q, read12_d;
    logic        read34_q, read34_d;
    logic [7:0]  adc_q, adc_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [31:0] fdata_q, fdata_d;

    // Phases with a trailing bus-turnaround gap stay in their state for one extra
    // count (cnt == length) with all controls low, instead of using separate gap states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        exp_d   = exp_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_ERASE;
                    exp_d   = (exp_cycles == '0) ? 16'd1 : exp_cycles;
                end
            end
            S_ERASE: begin
                if (cnt_q == ERASE_LEN) begin
                    state_d = S_EXPOSE;
                    cnt_d   = '0;
                end
            end
            S_EXPOSE: begin
                if (cnt_q == exp_q) begin
                    state_d = S_CONVERT;
                    cnt_d   = '0;
                end
            end
            S_CONVERT: begin
                if (cnt_q == CONV_LEN) begin
                    state_d = S_READ12;
                    cnt_d   = '0;
                end
            end
            S_READ12: begin
                if (cnt_q == READ_LAST) begin
                    state_d = S_READ34;
                    cnt_d   = '0;
                end
            end
            S_READ34: begin
                if (cnt_q == READ_LEN) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                end
            end
            S_OUT: begin
                cnt_d = '0;
                if (frame_ready) begin
                    if (cont_mode) begin
                        state_d = S_ERASE;
                        exp_d   = (exp_cycles == '0) ? 16'd1 : exp_cycles;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        erase_d   = (state_d == S_ERASE)   && (cnt_d < ERASE_LEN);
        expose_d  = (state_d == S_EXPOSE)  && (cnt_d < exp_d);
        convert_d = (state_d == S_CONVERT) && (cnt_d < CONV_LEN);
        read12_d  = (state_d == S_READ12)  && (cnt_d < READ_LEN);
        read34_d  = (state_d == S_READ34)  && (cnt_d < READ_LEN);
        adc_d     = '0;
        if (convert_d) begin
            adc_d = (cnt_d > 16'd255) ? 8'hFF : cnt_d[7:0];
        end
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_OUT);
        fdata_d = valid_d ? {pix34_q, pix12_q} : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            exp_q     <= 16'd1;
            pix12_q   <= '0;
            pix34_q   <= '0;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            read12_q  <= 1'b0;
            read34_q  <= 1'b0;
            adc_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            fdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            erase_q   <= erase_d;
            expose_q  <= expose_d;
            convert_q <= convert_d;
            read12_q  <= read12_d;
            read34_q  <= read34_d;
            adc_q     <= adc_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            fdata_q   <= fdata_d;
            if (state_q == S_READ12 && cnt_q == READ_LAST) begin
                pix12_q <= {pix_data2, pix_data1};
            end
            if (state_q == S_READ34 && cnt_q == READ_LAST) begin
                pix34_q <= {pix_data4, pix_data3};
            end
        end
    end

    assign erase       = erase_q;
    assign expose      = expose_q;
    assign convert     = convert_q;
    assign read12      = read12_q;
    assign read34      = read34_q;
    assign adc_count   = adc_q;
    assign busy        = busy_q;
    assign frame_valid = valid_q;
    assign frame_data  = fdata_q;

endmodule
